cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares one memory-side read/write channel pair between the instruction cache (read-only) and the data cache (read and write).
- Sits between the two cache instances and the AXI bridge.
- Serialises line and uncached reads (one outstanding read at a time) and routes return beats to the owning cache.
- Buffers one dcache write and blocks reads that hit the buffered line until the write drains.

Parameters:
- LINE_W, 128, write data width in bits (one cache line, 16 bytes).
- ADDR_W, 32, physical address width.
- LINE_OFF, 4, line offset bits; line address is addr[ADDR_W-1:LINE_OFF].

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- ic_rd_req  in  1  icache read request, held until ic_rd_rdy.
- ic_rd_type  in  3  010 word, 100 line.
- ic_rd_addr  in  ADDR_W  icache read address.
- ic_rd_rdy  out  1  icache request accepted this cycle.
- ic_ret_valid  out  1  return beat valid to icache.
- ic_ret_last  out  1  last beat to icache.
- ic_ret_data  out  32  return data to icache.
- dc_rd_req  in  1  dcache read request.
- dc_rd_type  in  3  dcache read type.
- dc_rd_addr  in  ADDR_W  dcache read address.
- dc_rd_rdy  out  1  dcache read request accepted.
- dc_ret_valid  out  1  return beat valid to dcache.
- dc_ret_last  out  1  last beat to dcache.
- dc_ret_data  out  32  return data to dcache.
- dc_wr_req  in  1  single-cycle write pulse; only issued while dc_wr_rdy=1.
- dc_wr_type  in  3  dcache write type.
- dc_wr_addr  in  ADDR_W  dcache write address.
- dc_wr_wstrb  in  4  word byte strobes.
- dc_wr_data  in  LINE_W  dcache write data.
- dc_wr_rdy  out  1  write buffer empty.
- mem_rd_req  out  1  memory read request.
- mem_rd_type  out  3  memory read type.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_rdy  in  1  memory accepts read request.
- mem_ret_valid  in  1  memory return beat valid.
- mem_ret_last  in  1  last memory return beat.
- mem_ret_data  in  32  memory return data.
- mem_wr_req  out  1  memory write request.
- mem_wr_type  out  3  memory write type.
- mem_wr_addr  out  ADDR_W  memory write address.
- mem_wr_wstrb  out  4  memory write strobes.
- mem_wr_data  out  LINE_W  memory write data.
- mem_wr_rdy  in  1  memory accepts write.
- err  out  1  sticky protocol error.

Behaviour:
- Single clock clk. Reset: asynchronous, active-low resetn.
- Reset: both FSMs idle, owner=IC, all outputs 0, err=0. Reset mid-transfer drops the transaction; the memory side is reset together with the arbiter.

Read FSM, states R_IDLE, R_REQ, R_RESP:
- R_IDLE: a candidate is blocked if the write buffer is full and its addr[ADDR_W-1:LINE_OFF] equals the buffered line address.
- R_IDLE grant: dc_rd_rdy = dc_rd_req && !dc_blocked. ic_rd_rdy = ic_rd_req && !ic_blocked && !dc_rd_rdy (fixed dcache priority).
- On any grant: latch owner/type/addr and go to R_REQ next cycle. Accept-to-mem_rd_req latency is 1 cycle.
- R_REQ: mem_rd_req=1 with latched type/addr. On mem_rd_rdy go to R_RESP.
- R_RESP: mem_ret_* is forwarded combinationally to the owner only; the other cache sees ret_valid=0.
- R_RESP exit: on mem_ret_valid && mem_ret_last go to R_IDLE. A new grant is possible the following cycle, not the same cycle.
- Uncached word reads are single beat with last=1; the arbiter does not count beats.
- Errors: mem_ret_valid outside R_RESP is dropped and sets err. dc_wr_req while dc_wr_rdy=0 sets err and is ignored.

Write buffer, states W_EMPTY, W_FULL:
- dc_wr_rdy = W_EMPTY.
- dc_wr_req in W_EMPTY latches type/addr/wstrb/data and goes to W_FULL.
- W_FULL: mem_wr_req=1 with latched fields; on mem_wr_rdy go to W_EMPTY, so dc_wr_rdy=1 the next cycle.
- No bypass: a write pulse cannot be accepted in the same cycle as a drain.
- Read and write channels progress independently; a read to a different line proceeds while the buffer is full.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: icache/dcache read priority is round-robin. A last_grant bit flips on each grant; when both request, the one not granted last wins. last_grant resets to IC, so dcache wins the first tie.
- Undefined: fixed dcache priority as described above.
- Blocking, latency and err behaviour are identical in both builds.

Test Plan:
- ic_rd_req line 0x1C000040, mem accepts after 2 cycles, 4 beats A0..A3 -> ic_rd_rdy high 1 cycle; mem_rd_addr=0x1C000040, type=100; ic_ret_valid on 4 beats, ic_ret_last on A3; dc_ret_valid stays 0.
- ic and dc read requested same cycle (0x1000, 0x2000) -> default build: dc granted first, ic granted the cycle after the dc last beat; ARB_RR_EN build: first tie to dc, second tie to ic.
- dc_wr_req line 0x3000 with mem_wr_rdy held 0, then dc_rd_req 0x3008 and ic_rd_req 0x5000 -> ic granted, dc blocked; after mem_wr_rdy pulse dc_rd_rdy asserts the next R_IDLE cycle.
- Write buffer full, second dc_wr_req pulse -> err=1 (sticky), buffer contents and mem_wr_* unchanged.
- Uncached dc read type=010 addr 0x1FD0_0004, single beat ret_last=1 data 0xDEADBEEF -> dc_ret_data=0xDEADBEEF, FSM back in R_IDLE the next cycle.
- resetn low during R_RESP after 2 beats -> all outputs 0 immediately; after release a fresh ic request is granted normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache line and uncached reads onto one memory read channel
// and buffers a single dcache write. Define ARB_RR_EN for round-robin read priority.
module cache_mem_arbiter #(
  parameter int LINE_W   = 128,
  parameter int ADDR_W   = 32,
  parameter int LINE_OFF = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ic_rd_req,
  input  logic [2:0]        ic_rd_type,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [31:0]       ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [2:0]        dc_rd_type,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [31:0]       dc_ret_data,
  input  logic              dc_wr_req,
  input  logic [2:0]        dc_wr_type,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [3:0]        dc_wr_wstrb,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_wr_rdy,
  output logic              mem_rd_req,
  output logic [2:0]        mem_rd_type,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_rdy,
  input  logic              mem_ret_valid,
  input  logic              mem_ret_last,
  input  logic [31:0]       mem_ret_data,
  output logic              mem_wr_req,
  output logic [2:0]        mem_wr_type,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [3:0]        mem_wr_wstrb,
  output logic [LINE_W-1:0] mem_wr_data,
  input  logic              mem_wr_rdy,
  output logic              err
);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rd_state_t;
  typedef enum logic       {W_EMPTY, W_FULL}       wr_state_t;
  typedef enum logic       {OWN_IC, OWN_DC}        owner_t;

  rd_state_t r_state;
  wr_state_t w_state;
  owner_t    owner;
`ifdef ARB_RR_EN
  owner_t    last_grant;
`endif

  logic ic_cand, dc_cand, dc_win, rd_idle, in_resp;

  // Grants are gated by resetn so no handshake completes while the flops are held.
  always_comb begin
    ic_cand = ic_rd_req && !(w_state == W_FULL &&
              ic_rd_addr[ADDR_W-1:LINE_OFF] == mem_wr_addr[ADDR_W-1:LINE_OFF]);
    dc_cand = dc_rd_req && !(w_state == W_FULL &&
              dc_rd_addr[ADDR_W-1:LINE_OFF] == mem_wr_addr[ADDR_W-1:LINE_OFF]);
`ifdef ARB_RR_EN
    dc_win  = dc_cand && (!ic_cand || last_grant == OWN_IC);
`else
    dc_win  = dc_cand;
`endif
    rd_idle = resetn && (r_state == R_IDLE);
    in_resp = (r_state == R_RESP);

    dc_rd_rdy    = rd_idle && dc_win;
    ic_rd_rdy    = rd_idle && ic_cand && !dc_win;
    dc_wr_rdy    = resetn && (w_state == W_EMPTY);

    ic_ret_valid = in_resp && owner == OWN_IC && mem_ret_valid;
    ic_ret_last  = in_resp && owner == OWN_IC && mem_ret_valid && mem_ret_last;
    ic_ret_data  = (in_resp && owner == OWN_IC) ? mem_ret_data : '0;
    dc_ret_valid = in_resp && owner == OWN_DC && mem_ret_valid;
    dc_ret_last  = in_resp && owner == OWN_DC && mem_ret_valid && mem_ret_last;
    dc_ret_data  = (in_resp && owner == OWN_DC) ? mem_ret_data : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= R_IDLE;
      owner       <= OWN_IC;
`ifdef ARB_RR_EN
      last_grant  <= OWN_IC;
`endif
      mem_rd_req  <= 1'b0;
      mem_rd_type <= '0;
      mem_rd_addr <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (dc_rd_rdy || ic_rd_rdy) begin
            owner       <= dc_rd_rdy ? OWN_DC : OWN_IC;
`ifdef ARB_RR_EN
            last_grant  <= dc_rd_rdy ? OWN_DC : OWN_IC;
`endif
            mem_rd_type <= dc_rd_rdy ? dc_rd_type : ic_rd_type;
            mem_rd_addr <= dc_rd_rdy ? dc_rd_addr : ic_rd_addr;
            mem_rd_req  <= 1'b1;
            r_state     <= R_REQ;
          end
        end
        R_REQ: begin
          if (mem_rd_rdy) begin
            mem_rd_req <= 1'b0;
            r_state    <= R_RESP;
          end
        end
        R_RESP: begin
          if (mem_ret_valid && mem_ret_last)
            r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state      <= W_EMPTY;
      mem_wr_req   <= 1'b0;
      mem_wr_type  <= '0;
      mem_wr_addr  <= '0;
      mem_wr_wstrb <= '0;
      mem_wr_data  <= '0;
    end else begin
      case (w_state)
        W_EMPTY: begin
          if (dc_wr_req) begin
            mem_wr_type  <= dc_wr_type;
            mem_wr_addr  <= dc_wr_addr;
            mem_wr_wstrb <= dc_wr_wstrb;
            mem_wr_data  <= dc_wr_data;
            mem_wr_req   <= 1'b1;
            w_state      <= W_FULL;
          end
        end
        W_FULL: begin
          if (mem_wr_rdy) begin
            mem_wr_req <= 1'b0;
            w_state    <= W_EMPTY;
          end
        end
        default: w_state <= W_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      err <= 1'b0;
    else if ((mem_ret_valid && r_state != R_RESP) || (dc_wr_req && w_state == W_FULL))
      err <= 1'b1;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  logic         clk = 1'b0;
  logic         resetn;
  logic         ic_rd_req;
  logic [2:0]   ic_rd_type;
  logic [31:0]  ic_rd_addr;
  logic         ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic [31:0]  ic_ret_data;
  logic         dc_rd_req;
  logic [2:0]   dc_rd_type;
  logic [31:0]  dc_rd_addr;
  logic         dc_rd_rdy, dc_ret_valid, dc_ret_last;
  logic [31:0]  dc_ret_data;
  logic         dc_wr_req;
  logic [2:0]   dc_wr_type;
  logic [31:0]  dc_wr_addr;
  logic [3:0]   dc_wr_wstrb;
  logic [127:0] dc_wr_data;
  logic         dc_wr_rdy;
  logic         mem_rd_req;
  logic [2:0]   mem_rd_type;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_rdy, mem_ret_valid, mem_ret_last;
  logic [31:0]  mem_ret_data;
  logic         mem_wr_req;
  logic [2:0]   mem_wr_type;
  logic [31:0]  mem_wr_addr;
  logic [3:0]   mem_wr_wstrb;
  logic [127:0] mem_wr_data;
  logic         mem_wr_rdy;
  logic         err;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] WDATA = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  cache_mem_arbiter #(.LINE_W(128), .ADDR_W(32), .LINE_OFF(4)) dut (
    .clk(clk), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
    .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
    .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
    .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
    .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
    .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
    .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
    .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
    .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C000040;
    dc_rd_req = 1'b0; dc_rd_type = 3'b100; dc_rd_addr = '0;
    dc_wr_req = 1'b0; dc_wr_type = 3'b100; dc_wr_addr = '0; dc_wr_wstrb = '0; dc_wr_data = '0;
    mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = '0;
    mem_wr_rdy = 1'b0;

    tick(); #2;
    chk("rst_ic_rd_rdy", ic_rd_rdy === 1'b0);
    chk("rst_dc_wr_rdy", dc_wr_rdy === 1'b0);
    chk("rst_mem_rd_req", mem_rd_req === 1'b0);
    chk("rst_mem_wr_req", mem_wr_req === 1'b0);
    chk("rst_err", err === 1'b0);
    resetn = 1'b1;
    #1;
    chk("rel_dc_wr_rdy", dc_wr_rdy === 1'b1);

    chk("ic_grant", ic_rd_rdy === 1'b1);
    chk("ic_grant_dc", dc_rd_rdy === 1'b0);
    tick(); ic_rd_req = 1'b0; #2;
    chk("ic_req", mem_rd_req === 1'b1);
    chk("ic_req_addr", mem_rd_addr === 32'h1C000040);
    chk("ic_req_type", mem_rd_type === 3'b100);
    chk("ic_rdy_once", ic_rd_rdy === 1'b0);
    tick(); #2;
    chk("ic_req_hold", mem_rd_req === 1'b1);
    tick(); mem_rd_rdy = 1'b1;
    tick(); mem_rd_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ret_valid = 1'b1; mem_ret_last = (i == 3); mem_ret_data = 32'hA0A00000 + 32'(i);
      #2;
      chk("ic_beat_valid", ic_ret_valid === 1'b1);
      chk("ic_beat_data", ic_ret_data === 32'hA0A00000 + 32'(i));
      chk("ic_beat_last", ic_ret_last === (i == 3));
      chk("ic_beat_dc_valid", dc_ret_valid === 1'b0);
      tick();
    end
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0; #2;
    chk("ic_done_req", mem_rd_req === 1'b0);
    chk("ic_done_err", err === 1'b0);

    ic_rd_req = 1'b1; ic_rd_addr = 32'h1000; dc_rd_req = 1'b1; dc_rd_addr = 32'h2000; #2;
    chk("tieA_dc_rdy", dc_rd_rdy === 1'b1);
    chk("tieA_ic_rdy", ic_rd_rdy === 1'b0);
    tick(); dc_rd_req = 1'b0; mem_rd_rdy = 1'b1; #2;
    chk("tieA_dc_addr", mem_rd_addr === 32'h2000);
    tick(); mem_rd_rdy = 1'b0;
    mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'h11111111; #2;
    chk("tieA_dc_ret", dc_ret_valid === 1'b1);
    chk("tieA_ic_ret", ic_ret_valid === 1'b0);
    chk("tieA_no_same_cycle", ic_rd_rdy === 1'b0);
    tick(); mem_ret_valid = 1'b0; mem_ret_last = 1'b0; #2;
    chk("tieA_ic_next", ic_rd_rdy === 1'b1);
    tick(); ic_rd_req = 1'b0; mem_rd_rdy = 1'b1; #2;
    chk("tieA_ic_addr", mem_rd_addr === 32'h1000);
    tick(); mem_rd_rdy = 1'b0;
    mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'h22222222; #2;
    chk("tieA_ic_ret_data", ic_ret_data === 32'h22222222);
    tick(); mem_ret_valid = 1'b0; mem_ret_last = 1'b0;

    dc_rd_req = 1'b1; dc_rd_type = 3'b010; dc_rd_addr = 32'h1FD00004; #2;
    chk("unc_grant", dc_rd_rdy === 1'b1);
    tick(); dc_rd_req = 1'b0; mem_rd_rdy = 1'b1; #2;
    chk("unc_type", mem_rd_type === 3'b010);
    tick(); mem_rd_rdy = 1'b0;
    mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'hDEADBEEF; #2;
    chk("unc_data", dc_ret_data === 32'hDEADBEEF);
    chk("unc_last", dc_ret_last === 1'b1);
    tick(); mem_ret_valid = 1'b0; mem_ret_last = 1'b0;

    dc_rd_type = 3'b100;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h1000; dc_rd_req = 1'b1; dc_rd_addr = 32'h2000; #2;
`ifdef ARB_RR_EN
    chk("tieB_ic_rdy", ic_rd_rdy === 1'b1);
    chk("tieB_dc_rdy", dc_rd_rdy === 1'b0);
`else
    chk("tieB_ic_rdy", ic_rd_rdy === 1'b0);
    chk("tieB_dc_rdy", dc_rd_rdy === 1'b1);
`endif
    tick(); ic_rd_req = 1'b0; dc_rd_req = 1'b0; mem_rd_rdy = 1'b1;
    tick(); mem_rd_rdy = 1'b0; mem_ret_valid = 1'b1; mem_ret_last = 1'b1;
    tick(); mem_ret_valid = 1'b0; mem_ret_last = 1'b0;

    dc_wr_req = 1'b1; dc_wr_addr = 32'h3000; dc_wr_wstrb = 4'hF; dc_wr_data = WDATA; #2;
    chk("wr_rdy_empty", dc_wr_rdy === 1'b1);
    tick(); dc_wr_req = 1'b0;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h3008; ic_rd_req = 1'b1; ic_rd_addr = 32'h5000; #2;
    chk("wr_mem_req", mem_wr_req === 1'b1);
    chk("wr_mem_addr", mem_wr_addr === 32'h3000);
    chk("wr_mem_data", mem_wr_data === WDATA);
    chk("wr_rdy_full", dc_wr_rdy === 1'b0);
    chk("wr_dc_blocked", dc_rd_rdy === 1'b0);
    chk("wr_ic_granted", ic_rd_rdy === 1'b1);
    tick(); ic_rd_req = 1'b0; mem_rd_rdy = 1'b1;
    dc_wr_req = 1'b1; dc_wr_addr = 32'h4000; dc_wr_data = ~WDATA; dc_wr_wstrb = 4'h1; #2;
    chk("wr_ic_addr", mem_rd_addr === 32'h5000);
    chk("wr_err_before", err === 1'b0);
    tick(); dc_wr_req = 1'b0; mem_rd_rdy = 1'b0;
    mem_ret_valid = 1'b1; mem_ret_last = 1'b1; mem_ret_data = 32'h55555555; #2;
    chk("wr_err_set", err === 1'b1);
    chk("wr_keep_addr", mem_wr_addr === 32'h3000);
    chk("wr_keep_data", mem_wr_data === WDATA);
    chk("wr_keep_wstrb", mem_wr_wstrb === 4'hF);
    chk("wr_ic_ret", ic_ret_valid === 1'b1);
    tick(); mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_wr_rdy = 1'b1; #2;
    chk("wr_idle_blocked", dc_rd_rdy === 1'b0);
    tick(); mem_wr_rdy = 1'b0; #2;
    chk("wr_drained_rdy", dc_wr_rdy === 1'b1);
    chk("wr_drained_req", mem_wr_req === 1'b0);
    chk("wr_dc_unblocked", dc_rd_rdy === 1'b1);
    chk("wr_err_sticky", err === 1'b1);
    tick(); dc_rd_req = 1'b0; mem_rd_rdy = 1'b1; #2;
    chk("wr_dc_addr", mem_rd_addr === 32'h3008);
    tick(); mem_rd_rdy = 1'b0; mem_ret_valid = 1'b1; mem_ret_last = 1'b1; #2;
    chk("wr_dc_ret", dc_ret_valid === 1'b1);
    tick(); mem_ret_valid = 1'b0; mem_ret_last = 1'b0;

    ic_rd_req = 1'b1; ic_rd_addr = 32'h1C000040; #2;
    chk("mid_grant", ic_rd_rdy === 1'b1);
    tick(); ic_rd_req = 1'b0; mem_rd_rdy = 1'b1;
    tick(); mem_rd_rdy = 1'b0; mem_ret_valid = 1'b1;
    tick();
    tick();
    resetn = 1'b0; #1;
    chk("mid_rst_ret", ic_ret_valid === 1'b0);
    chk("mid_rst_data", ic_ret_data === 32'h0);
    chk("mid_rst_err", err === 1'b0);
    chk("mid_rst_wr_rdy", dc_wr_rdy === 1'b0);
    mem_ret_valid = 1'b0;
    tick(); resetn = 1'b1; ic_rd_req = 1'b1; ic_rd_addr = 32'h6000; #2;
    chk("post_rst_grant", ic_rd_rdy === 1'b1);
    tick(); ic_rd_req = 1'b0; mem_rd_rdy = 1'b1; #2;
    chk("post_rst_addr", mem_rd_addr === 32'h6000);
    tick(); mem_rd_rdy = 1'b0; mem_ret_valid = 1'b1; mem_ret_last = 1'b1;
    tick(); mem_ret_valid = 1'b0; mem_ret_last = 1'b0; #2;
    chk("post_rst_err", err === 1'b0);

    mem_ret_valid = 1'b1; #2;
    chk("stray_no_fwd", ic_ret_valid === 1'b0);
    tick(); mem_ret_valid = 1'b0; #2;
    chk("stray_err", err === 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
